mul_cpa: RTL and testbench

MUL_CPA -- requirements
Module: mul_cpa

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_cpa_if.sv | 27 ++
 rtl/cpa_half.sv | 14 +
 rtl/mul_cpa.sv | 106 ++++++++++
 tb/tb_mul_cpa.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared width constants and the stage-1 pipeline register layout for mul_cpa.
package mul_pkg;

  localparam int W = 64;
  localparam int H = W / 2;

  typedef struct packed {
    logic         valid;
    logic         long_res;
    logic         carry;
    logic [H-1:0] lo_sum;
    logic [H-1:0] hi_a;
    logic [H-1:0] hi_b;
  } stage1_t;

endpackage

// File: rtl/mul_cpa_if.sv
// Input bundle and result handshake of mul_cpa; master drives operands, slave is the adder.
interface mul_cpa_if #(parameter int W = mul_pkg::W);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s0;
  logic [W-1:0] s1;
  logic [W-1:0] acc;
  logic         acc_en;
  logic         long;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_n;
  logic         flag_z;

  modport master (
    output in_valid, s0, s1, acc, acc_en, long, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z
  );

  modport slave (
    input  in_valid, s0, s1, acc, acc_en, long, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z
  );

endinterface

// File: rtl/cpa_half.sv
// Half-width carry-propagate adder; one copy per pipeline stage of mul_cpa.
module cpa_half #(
  parameter int H = mul_pkg::H
) (
  input  logic [H-1:0] a,
  input  logic [H-1:0] b,
  input  logic         cin,
  output logic [H-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{H{1'b0}}, cin};

endmodule

// File: rtl/mul_cpa.sv
// Two-stage split carry-propagate adder for the multiplier's final sum/carry vectors.
// Optional accumulate (3:2 row ahead of the adder) is built when MUL_CPA_ACC_EN is defined.
module mul_cpa #(
  parameter int W = mul_pkg::W
) (
  input  logic      clk,
  input  logic      rst,
  mul_cpa_if.slave  bus
);
  import mul_pkg::*;

  logic [W-1:0] op_a, op_b, op_x, op_y;
  logic [H-1:0] lo_sum, hi_sum;
  logic         lo_cout, hi_cout;
  logic         unused_bits;

  assign op_a = bus.s0;
  assign op_b = {bus.s1[W-2:0], 1'b0};

`ifdef MUL_CPA_ACC_EN
  logic [W-1:0] op_c, maj;
  assign op_c = bus.acc_en ? bus.acc : '0;
  assign maj  = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
  assign op_x = op_a ^ op_b ^ op_c;
  // Majority bits carry weight 2^(i+1); the top one falls off the W-bit result.
  assign op_y = {maj[W-2:0], 1'b0};
  assign unused_bits = ^{bus.s1[W-1], maj[W-1], hi_cout};
`else
  assign op_x = op_a;
  assign op_y = op_b;
  assign unused_bits = ^{bus.s1[W-1], bus.acc, bus.acc_en, hi_cout};
`endif

  cpa_half #(.H(H)) u_lo (
    .a    (op_x[H-1:0]),
    .b    (op_y[H-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  stage1_t      st1;
  logic         out_valid_q, flag_n_q, flag_z_q;
  logic [W-1:0] result_q;
  logic         s1_ready, s2_ready, take_in;

  // A stage may load when it is empty or its content moves on this cycle.
  assign s2_ready     = !out_valid_q || bus.out_ready;
  assign s1_ready     = !st1.valid || s2_ready;
  assign take_in      = bus.in_valid && s1_ready;
  assign bus.in_ready = s1_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      st1 <= '0;
    end else if (s1_ready) begin
      st1.valid <= take_in;
      if (take_in) begin
        st1.long_res <= bus.long;
        st1.carry    <= lo_cout;
        st1.lo_sum   <= lo_sum;
        st1.hi_a     <= op_x[W-1:H];
        st1.hi_b     <= op_y[W-1:H];
      end
    end
  end

  cpa_half #(.H(H)) u_hi (
    .a    (st1.hi_a),
    .b    (st1.hi_b),
    .cin  (st1.carry),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  logic [W-1:0] result_next;
  logic         flag_n_next, flag_z_next;

  assign result_next = st1.long_res ? {hi_sum, st1.lo_sum} : {{(W-H){1'b0}}, st1.lo_sum};
  assign flag_n_next = st1.long_res ? hi_sum[H-1] : st1.lo_sum[H-1];
  assign flag_z_next = (result_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= st1.valid;
      if (st1.valid) begin
        result_q <= result_next;
        flag_n_q <= flag_n_next;
        flag_z_q <= flag_z_next;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_cpa.sv
// Self-checking bench for mul_cpa: directed table, backpressure/reset sequences, random traffic.
module tb_mul_cpa;
  import mul_pkg::*;

`ifdef MUL_CPA_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_cpa_if #(.W(W)) bus ();
  mul_cpa #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] s0, s1, acc;
    logic         acc_en, lng;
    logic [W-1:0] res;
    logic         n, z;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         n, z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_hold = 1'b0;
  exp_t prev_out;
  logic fired_in, fired_out;
  vec_t idle = '{default: '0};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain W-bit modular sum, then truncation/flags by result mode.
  function automatic exp_t model(input vec_t v);
    exp_t         e;
    logic [W-1:0] sum;
    sum = v.s0 + (v.s1 << 1);
    if (ACC_ON && v.acc_en) sum = sum + v.acc;
    if (!v.lng) sum = sum & {{(W-H){1'b0}}, {H{1'b1}}};
    e.res = sum;
    e.n   = v.lng ? sum[W-1] : sum[H-1];
    e.z   = (sum == '0);
    return e;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.s0     = {$urandom(), $urandom()};
    v.s1     = {$urandom(), $urandom()};
    v.acc    = {$urandom(), $urandom()};
    v.acc_en = 1'($urandom_range(0, 1));
    v.lng    = 1'($urandom_range(0, 1));
    v.res    = '0;
    v.n      = 1'b0;
    v.z      = 1'b0;
    return v;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, score handshakes, wait for next negedge.
  task automatic cycle(input logic iv, input logic ordy, input vec_t v, input logic use_model);
    exp_t e;
    bus.in_valid  = iv;
    bus.s0        = v.s0;
    bus.s1        = v.s1;
    bus.acc       = v.acc;
    bus.acc_en    = v.acc_en;
    bus.long      = v.lng;
    bus.out_ready = ordy;
    #1;
    fired_in  = iv && bus.in_ready;
    fired_out = bus.out_valid && ordy;
    if (prev_hold) begin
      check("hold_result", bus.result, prev_out.res);
      check("hold_flag_n", bus.flag_n, prev_out.n);
      check("hold_flag_z", bus.flag_z, prev_out.z);
    end
    if (fired_out) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %h, expected no result", bus.result);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("flag_n", bus.flag_n, e.n);
        check("flag_z", bus.flag_z, e.z);
      end
    end
    if (fired_in) begin
      if (use_model) sb.push_back(model(v));
      else           sb.push_back('{v.res, v.n, v.z});
    end
    prev_hold = bus.out_valid && !ordy;
    prev_out  = '{bus.result, bus.flag_n, bus.flag_z};
    @(negedge clk);
  endtask

  // Reset for one edge with an input offered, then check the cleared state.
  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_hold = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_result", bus.result, '0);
    check("rst_flag_n", bus.flag_n, 1'b0);
    check("rst_flag_z", bus.flag_z, 1'b0);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(1'b0, 1'b1, idle, 1'b0);
    check(name, sb.size(), 0);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t bp[3];
    vec_t v;
    int   accepted;

    tbl[0] = '{64'h5, 64'h3, 64'h0, 1'b0, 1'b1, 64'hB, 1'b0, 1'b0};
    tbl[1] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1, 64'h0000_0001_0000_0001, 1'b0, 1'b0};
    tbl[2] = '{'1, 64'h0, 64'h1, 1'b1, 1'b1, ACC_ON ? 64'h0 : '1, !ACC_ON, ACC_ON};
    tbl[3] = '{64'h8000_0000, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 1'b1, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0,
               64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0};
    tbl[5] = '{64'h1_0000_0000, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[6] = '{64'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b0, 1'b1, 64'h0, 1'b0, 1'b1};
    tbl[7] = '{64'h1, 64'h1, 64'h100, 1'b1, 1'b1, ACC_ON ? 64'h103 : 64'h3, 1'b0, 1'b0};
    tbl[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'hFF, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    tbl[9] = '{64'h4000_0000_0000_0000, 64'h2000_0000_0000_0000, 64'h0, 1'b0, 1'b1,
               64'h8000_0000_0000_0000, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.s0        = '0;
    bus.s1        = '0;
    bus.acc       = '0;
    bus.acc_en    = 1'b0;
    bus.long      = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed vectors, one at a time, with exact two-cycle latency.
    foreach (tbl[i]) begin
      cycle(1'b1, 1'b1, tbl[i], 1'b0);
      check("vec_accept", fired_in, 1'b1);
      check("vec_lat1_valid", bus.out_valid, 1'b0);
      cycle(1'b0, 1'b1, idle, 1'b0);
      check("vec_lat2_valid", bus.out_valid, 1'b1);
      cycle(1'b0, 1'b1, idle, 1'b0);
    end
    drain("vec_drained");

    // Backpressure: three offers against a stalled consumer.
    foreach (bp[i]) bp[i] = rand_vec();
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(accepted < 3, 1'b0, (accepted < 3) ? bp[accepted] : idle, 1'b1);
      if (fired_in) accepted++;
    end
    check("bp_accepts", accepted, 2);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_out_valid", bus.out_valid, 1'b1);
    for (int c = 0; c < 20 && !(accepted == 3 && sb.size() == 0); c++) begin
      cycle(accepted < 3, 1'b1, (accepted < 3) ? bp[accepted] : idle, 1'b1);
      if (fired_in) accepted++;
    end
    check("bp_all_accepted", accepted, 3);
    check("bp_drained", sb.size(), 0);

    // Reset one cycle after an accept: that result must never appear.
    v = idle;
    v.s0  = 64'h1234;
    v.lng = 1'b1;
    cycle(1'b1, 1'b1, v, 1'b1);
    check("rst_mid_accept", fired_in, 1'b1);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b1, idle, 1'b0);
      check("rst_no_stale", bus.out_valid, 1'b0);
    end

    // Random traffic against the arithmetic model.
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_vec(), 1'b1);
    end
    drain("rand_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
